// File: rtl/ex_mem_wb_dest_pipe_pkg.sv
// Shared definitions for the EX/MEM/WB destination-register pipeline:
// default widths and the ALU operand forward-select encoding, which the
// EX-stage operand muxes decode with the same constants.
package ex_mem_wb_dest_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  // Resolve the two stage hits into a select. EX/MEM holds the newer
  // value, so it wins when both stages write the same register.
  function automatic logic [1:0] fwd_priority(input logic mem_hit,
                                              input logic wb_hit);
    logic [1:0] sel;
    case ({mem_hit, wb_hit})
      2'b10:   sel = FWD_MEM;
      2'b11:   sel = FWD_MEM;
      2'b01:   sel = FWD_WB;
      2'b00:   sel = FWD_RF;
      default: sel = FWD_RF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_mem_wb_dest_pipe_fwd_select.sv
// Forward select for one ALU operand: compares the operand's source
// register against the qualified destinations held in EX/MEM and MEM/WB.
// Register $0 never matches because $0 writes are dropped at pipeline
// entry, so the write-enable qualification alone keeps $0 at FWD_RF.
module fwd_select
  import ex_mem_wb_dest_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_write_reg,
  output logic [1:0]       fwd_sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  // Per-stage hazard detection followed by newest-wins priority.
  always_comb begin
    mem_hit_s = 1'b0;
    wb_hit_s  = 1'b0;
    if (mem_reg_write && (mem_write_reg == src_reg)) begin
      mem_hit_s = 1'b1;
    end else begin
      mem_hit_s = 1'b0;
    end
    if (wb_reg_write && (wb_write_reg == src_reg)) begin
      wb_hit_s = 1'b1;
    end else begin
      wb_hit_s = 1'b0;
    end
    fwd_sel = fwd_priority(mem_hit_s, wb_hit_s);
  end

endmodule

// File: rtl/ex_mem_wb_dest_pipe.sv
// EX/MEM and MEM/WB pipeline registers for the destination register and
// its write-back controls, write-back data formation, and the operand
// forwarding selects returned to the EX stage.
module ex_mem_wb_dest_pipe
  import ex_mem_wb_dest_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [REG_W-1:0]  ex_rs,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_write_data,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);

  logic [REG_W-1:0]  mem_write_reg_r;
  logic              mem_reg_write_r;
  logic              mem_mem_to_reg_r;
  logic [DATA_W-1:0] mem_alu_result_r;
  logic [REG_W-1:0]  wb_write_reg_r;
  logic              wb_reg_write_r;
  logic [DATA_W-1:0] wb_write_data_r;

  logic              ex_write_qual_s;
  logic [DATA_W-1:0] wb_data_sel_s;

  // Entry qualification (no $0 writes) and write-back data selection.
  always_comb begin
    ex_write_qual_s = 1'b0;
    wb_data_sel_s   = {DATA_W{1'b0}};
    if (ex_reg_write && (ex_write_reg != {REG_W{1'b0}})) begin
      ex_write_qual_s = 1'b1;
    end else begin
      ex_write_qual_s = 1'b0;
    end
    if (mem_mem_to_reg_r) begin
      wb_data_sel_s = mem_read_data;
    end else begin
      wb_data_sel_s = mem_alu_result_r;
    end
  end

  // EX/MEM register: reset > hold > flush (bubble) > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write_reg_r  <= {REG_W{1'b0}};
      mem_reg_write_r  <= 1'b0;
      mem_mem_to_reg_r <= 1'b0;
      mem_alu_result_r <= {DATA_W{1'b0}};
    end else if (hold) begin
      mem_write_reg_r  <= mem_write_reg_r;
      mem_reg_write_r  <= mem_reg_write_r;
      mem_mem_to_reg_r <= mem_mem_to_reg_r;
      mem_alu_result_r <= mem_alu_result_r;
    end else if (flush) begin
      mem_write_reg_r  <= {REG_W{1'b0}};
      mem_reg_write_r  <= 1'b0;
      mem_mem_to_reg_r <= 1'b0;
      mem_alu_result_r <= {DATA_W{1'b0}};
    end else begin
      mem_write_reg_r  <= ex_write_reg;
      mem_reg_write_r  <= ex_write_qual_s;
      mem_mem_to_reg_r <= ex_mem_to_reg;
      mem_alu_result_r <= ex_alu_result;
    end
  end

  // MEM/WB register: advances from old EX/MEM contents even during flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_write_reg_r  <= {REG_W{1'b0}};
      wb_reg_write_r  <= 1'b0;
      wb_write_data_r <= {DATA_W{1'b0}};
    end else if (hold) begin
      wb_write_reg_r  <= wb_write_reg_r;
      wb_reg_write_r  <= wb_reg_write_r;
      wb_write_data_r <= wb_write_data_r;
    end else begin
      wb_write_reg_r  <= mem_write_reg_r;
      wb_reg_write_r  <= mem_reg_write_r;
      wb_write_data_r <= wb_data_sel_s;
    end
  end

  assign mem_write_reg  = mem_write_reg_r;
  assign mem_reg_write  = mem_reg_write_r;
  assign mem_mem_to_reg = mem_mem_to_reg_r;
  assign mem_alu_result = mem_alu_result_r;
  assign wb_write_reg   = wb_write_reg_r;
  assign wb_reg_write   = wb_reg_write_r;
  assign wb_write_data  = wb_write_data_r;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src_reg       (ex_rs),
    .mem_reg_write (mem_reg_write_r),
    .mem_write_reg (mem_write_reg_r),
    .wb_reg_write  (wb_reg_write_r),
    .wb_write_reg  (wb_write_reg_r),
    .fwd_sel       (forward_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src_reg       (ex_rt),
    .mem_reg_write (mem_reg_write_r),
    .mem_write_reg (mem_write_reg_r),
    .wb_reg_write  (wb_reg_write_r),
    .wb_write_reg  (wb_write_reg_r),
    .fwd_sel       (forward_b)
  );

endmodule
